// File: rtl/i2s_pkg.sv
// Shared I2S definitions: link FSM states and the default frame geometry
// used by both the frame controller and the I2Srx receiver.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int SLOT_DEF  = 32;
  localparam int WIDTH_DEF = 16;

  // A slot must hold the sample plus the one-bit I2S delay.
  function automatic int slot_eff(input int slot, input int width);
    return (slot > width) ? slot : width + 1;
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// I2S bit-clock divider: toggles sclk every div_i+1 enabled clk cycles
// and strobes each edge in the cycle where sclk first shows it.
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             sclk_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             fall_nx_o
);

  logic [DIV_W-1:0] div_cnt;
  logic             tc;

  assign tc        = en_i && (div_cnt == div_i);
  assign fall_nx_o = tc && sclk_o;

  // divider count, sclk level and registered edge strobes
  always_ff @(posedge clk_i) begin
    if (!rst_i || !en_i) begin
      div_cnt <= '0;
      sclk_o  <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      sclk_o  <= ~sclk_o;
      rise_o  <= ~sclk_o;
      fall_o  <= sclk_o;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S master frame controller: sclk/ws generation, clean frame-aligned
// start/stop, packet counting and a missed-packet watchdog.
module i2s_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int SLOT  = SLOT_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] clkDiv_i,
  input  logic             pktRx_i,
  input  logic             clrErr_i,
  output logic             sclk_o,
  output logic             ws_o,
  output logic             sclkRise_o,
  output logic             sclkFall_o,
  output logic             frameStart_o,
  output logic             running_o,
  output logic             frameErr_o,
  output logic [CNT_W-1:0] pktCnt_o
);

  localparam int SLOT_C = slot_eff(SLOT, WIDTH);
  localparam int BW     = $clog2(2 * SLOT_C);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_C - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(SLOT_C);

  state_e           state_q;
  state_e           state_d;
  logic [DIV_W-1:0] div_reg;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_nx;
  logic [CNT_W-1:0] cnt_q;
  logic             ws_q;
  logic             fs_q;
  logic             armed_q;
  logic             seen_q;
  logic             err_q;
  logic             err_set;
  logic             run_en;
  logic             fall_nx;
  logic             bnd;

  i2s_clk_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (run_en),
    .div_i    (div_reg),
    .sclk_o   (sclk_o),
    .rise_o   (sclkRise_o),
    .fall_o   (sclkFall_o),
    .fall_nx_o(fall_nx)
  );

  // bnd: this edge drops sclk and wraps the frame
  assign bnd     = fall_nx && (bit_cnt == BIT_LAST);
  assign bit_nx  = bnd ? '0 : bit_cnt + 1'b1;
  // a pulse on the wrap edge still belongs to the ending frame
  assign err_set = bnd && armed_q && !seen_q && !pktRx_i;

  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state: stop only on a frame boundary
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable_i) state_d = RUN;
      RUN:     if (!enable_i) state_d = DRAIN;
      DRAIN: begin
        if (enable_i) state_d = RUN;
        else if (bnd) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state outputs
  always_comb begin
    run_en = 1'b0;
    unique case (state_q)
      RUN, DRAIN: run_en = 1'b1;
      default:    run_en = 1'b0;
    endcase
  end

  // bit counter, ws, frame strobe, watchdog and packet count
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      div_reg <= '0;
      bit_cnt <= '0;
      ws_q    <= 1'b0;
      fs_q    <= 1'b0;
      armed_q <= 1'b0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fs_q  <= bnd;
      err_q <= err_set | (err_q & ~clrErr_i);
      if (state_q == IDLE) begin
        bit_cnt <= '0;
        ws_q    <= 1'b0;
        if (enable_i) begin
          div_reg <= clkDiv_i;
          cnt_q   <= '0;
          armed_q <= 1'b0;
          seen_q  <= 1'b0;
        end
      end else begin
        if (fall_nx) begin
          bit_cnt <= bit_nx;
          ws_q    <= (bit_nx >= BIT_HALF);
        end
        if (pktRx_i) cnt_q <= cnt_q + 1'b1;
        if (bnd) begin
          armed_q <= 1'b1;
          seen_q  <= 1'b0;
        end else if (pktRx_i) begin
          seen_q <= 1'b1;
        end
      end
    end
  end

  assign ws_o         = ws_q;
  assign frameStart_o = fs_q;
  assign running_o    = run_en;
  assign frameErr_o   = err_q;
  assign pktCnt_o     = cnt_q;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Scoreboard bench for i2s_frame_ctrl: a timeline-arithmetic model
// predicts every output per clk; a monitor compares after each edge.
module tb_i2s_frame_ctrl;

  localparam int SLOT  = 32;
  localparam int WIDTH = 16;
  localparam int DIV_W = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic             sclk;
    logic             ws;
    logic             rise;
    logic             fall;
    logic             fs;
    logic             run;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] clk_div = '0;
  logic             pkt_rx = 1'b0;
  logic             clr_err = 1'b0;
  logic             sclk, ws, rise, fall, fs, running, ferr;
  logic [CNT_W-1:0] pcnt;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   checks = 0;
  int   errors = 0;

  // model: elapsed-edge timeline of the running link
  bit m_run, m_drain, m_err, m_pk;
  int m_t, m_d, m_frames, m_cnt;

  i2s_frame_ctrl #(
    .SLOT(SLOT), .WIDTH(WIDTH), .DIV_W(DIV_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .enable_i    (enable),
    .clkDiv_i    (clk_div),
    .pktRx_i     (pkt_rx),
    .clrErr_i    (clr_err),
    .sclk_o      (sclk),
    .ws_o        (ws),
    .sclkRise_o  (rise),
    .sclkFall_o  (fall),
    .frameStart_o(fs),
    .running_o   (running),
    .frameErr_o  (ferr),
    .pktCnt_o    (pcnt)
  );

  always #5 clk = ~clk;

  task automatic model(input bit en, input int div, input bit pkt,
                       input bit clr, input bit rst, output obs_t e);
    int p;
    bit fl, bnd, set;
    e   = '0;
    set = 1'b0;
    if (!rst) begin
      m_run = 0; m_drain = 0; m_err = 0; m_pk = 0;
      m_t = 0; m_d = 0; m_frames = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1; m_drain = 0; m_t = 0; m_d = div;
        m_cnt = 0; m_frames = 0; m_pk = 0;
      end
    end else begin
      m_t++;
      p   = m_d + 1;
      fl  = (m_t % (2 * p)) == 0;
      bnd = fl && ((m_t / (2 * p)) % (2 * SLOT)) == 0;
      e.rise = ((m_t % p) == 0) && !fl;
      e.fall = fl;
      e.fs   = bnd;
      if (pkt) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_pk  = 1;
      end
      if (bnd) begin
        set = (m_frames > 0) && !m_pk;
        m_frames++;
        m_pk = 0;
      end
      if (m_drain && !en && bnd) m_run = 0;
      m_drain = m_run && !en;
    end
    if (rst) m_err = set || (m_err && !clr);
    p      = m_d + 1;
    e.run  = m_run;
    e.err  = m_err;
    e.cnt  = m_cnt[CNT_W-1:0];
    e.sclk = m_run && ((m_t / p) % 2 == 1);
    e.ws   = m_run && (((m_t / (2 * p)) % (2 * SLOT)) >= SLOT);
  endtask

  function automatic bit m_bnd_next();
    int p;
    p = m_d + 1;
    return m_run && ((m_t + 1) % (2 * p) == 0)
           && (((m_t + 1) / (2 * p)) % (2 * SLOT) == 0);
  endfunction

  function automatic bit m_sclk_high();
    return m_run && ((m_t / (m_d + 1)) % 2 == 1);
  endfunction

  // one clk of stimulus; expected outputs go to the scoreboard
  task automatic step(input bit en, input int div, input bit pkt,
                      input bit clr, input bit rst);
    obs_t e;
    @(negedge clk);
    enable  = en;
    clk_div = div[DIV_W-1:0];
    pkt_rx  = pkt;
    clr_err = clr;
    rst_n   = rst;
    model(en, div, pkt, clr, rst, e);
    exp_q.push_back(e);
  endtask

  // a frame-length window with at most one packet and one clear
  task automatic run_frame(input int len, input bit send, input bit clr);
    int pos, cpos;
    pos  = $urandom_range(0, len - 1);
    cpos = $urandom_range(0, len - 1);
    for (int i = 0; i < len; i++)
      step(1, $urandom_range(0, 255), send && (i == pos),
           clr && (i == cpos), 1);
  endtask

  // run up to and including the next frame-boundary edge
  task automatic to_bnd(input bit en, input bit en_b, input bit pkt_b,
                        input bit clr_b);
    bit b, hit;
    hit = 0;
    for (int i = 0; i < 6000 && !hit; i++) begin
      b = m_bnd_next();
      step(b ? en_b : en, $urandom_range(0, 255),
           b && pkt_b, b && clr_b, 1);
      hit = b;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL boundary_wait: no frame boundary within 6000 clk");
    end
  endtask

  // monitor: compare each post-edge output set with the scoreboard
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e      = exp_q.pop_front();
      mon_a.sclk = sclk;
      mon_a.ws   = ws;
      mon_a.rise = rise;
      mon_a.fall = fall;
      mon_a.fs   = fs;
      mon_a.run  = running;
      mon_a.err  = ferr;
      mon_a.cnt  = pcnt;
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL outputs @%0t sclk,ws,rise,fall,fs,run,err,cnt got %b required %b",
                 $time, mon_a, mon_e);
      end
    end
  end

  initial begin
    // reset, then idle with stray packets
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (4) step(0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 1);

    // div=1: 4 good frames, a miss, clear, another miss
    step(1, 1, 0, 0, 1);
    for (int f = 0; f < 4; f++) run_frame(256, 1, 0);
    run_frame(256, 0, 0);
    run_frame(256, 1, 1);
    run_frame(256, 1, 0);
    // clear coincident with a new miss: set wins
    to_bnd(1, 1, 0, 1);
    step(1, 0, 0, 1, 1);
    // pulse only on the wrap edge still counts
    to_bnd(1, 1, 1, 0);
    to_bnd(1, 1, 0, 0);

    // stop at bitCnt ~10, drain to boundary, idle
    repeat (42) step(1, 0, 0, 0, 1);
    to_bnd(0, 0, 0, 0);
    repeat (20) step(0, 3, 0, 0, 1);

    // restart, dip enable during drain, then enable drop on a boundary
    step(1, 1, 0, 0, 1);
    repeat (50) step(1, 0, 1'($urandom_range(0, 1)), 0, 1);
    repeat (100) step(0, 0, 0, 0, 1);
    repeat (30) step(1, 0, 0, 0, 1);
    to_bnd(1, 0, 1, 0);
    to_bnd(0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 1);

    // div=0 with div changes mid-run and dense packets
    step(1, 0, 0, 0, 1);
    repeat (300)
      step(1, $urandom_range(0, 255), ($urandom_range(0, 2) == 0), 0, 1);

    // reset while sclk is high
    for (int i = 0; i < 50 && !m_sclk_high(); i++) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1);

    // 17 packets into a 4-bit counter
    step(1, 2, 0, 0, 1);
    repeat (17) step(1, 0, 1, 0, 1);
    repeat (10) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 1);

    // random soak
    begin
      bit en_r;
      en_r = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 299) == 0) en_r = !en_r;
        step(en_r, $urandom_range(0, 3), ($urandom_range(0, 59) == 0),
             ($urandom_range(0, 499) == 0), ($urandom_range(0, 1999) != 0));
      end
    end

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
